// File: rtl/i2c_target.sv
// I2C target (slave) with 7-bit address, byte write strobe and byte read request.
// SCL and SDA are synchronized into CLOCK; no clock stretching.
module i2c_target #(
  parameter logic [6:0]  ADDR = 7'h50,
  parameter int unsigned SYNC = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       sclin,
  input  logic       sdai,
  output logic       sdao,
  output logic       wrstb,
  output logic [7:0] wrdata,
  output logic       wrfirst,
  output logic       rdreq,
  input  logic [7:0] rddata,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AACK, S_WRBYTE, S_WACK, S_RDBYTE, S_RACK
  } state_t;

  state_t          state;
  logic [SYNC-1:0] scl_s, sda_s;
  logic            scl, sda, scl_d, sda_d;
  logic            start, stop, rise, fall;
  logic [7:0]      sr;
  logic [3:0]      cnt;
  logic            rw;
  logic            first_pend;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[SYNC-2:0], sclin};
      sda_s <= {sda_s[SYNC-2:0], sdai};
      scl_d <= scl;
      sda_d <= sda;
    end
  end

  assign scl   = scl_s[SYNC-1];
  assign sda   = sda_s[SYNC-1];
  assign start = scl & sda_d & ~sda;
  assign stop  = scl & ~sda_d & sda;
  assign rise  = scl & ~scl_d;
  assign fall  = ~scl & scl_d;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      sdao       <= 1'b1;
      wrstb      <= 1'b0;
      wrdata     <= '0;
      wrfirst    <= 1'b0;
      rdreq      <= 1'b0;
      busy       <= 1'b0;
      sr         <= '0;
      cnt        <= '0;
      rw         <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      wrstb <= 1'b0;
      rdreq <= 1'b0;
      if (start) begin
        state <= S_ADDR;
        cnt   <= '0;
        sdao  <= 1'b1;
        busy  <= 1'b0;
      end else if (stop) begin
        state <= S_IDLE;
        sdao  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (rise) begin
              sr  <= {sr[6:0], sda};
              cnt <= cnt + 4'd1;
            end else if (fall && cnt == 4'd8) begin
              if (sr[7:1] == ADDR) begin
                sdao  <= 1'b0;
                busy  <= 1'b1;
                rw    <= sr[0];
                state <= S_AACK;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_AACK: begin
            if (rise && rw) begin
              rdreq <= 1'b1;
            end else if (fall) begin
              cnt <= '0;
              if (!rw) begin
                sdao       <= 1'b1;
                first_pend <= 1'b1;
                state      <= S_WRBYTE;
              end else begin
                sr    <= rddata;
                sdao  <= rddata[7];
                state <= S_RDBYTE;
              end
            end
          end
          S_WRBYTE: begin
            if (rise) begin
              sr  <= {sr[6:0], sda};
              cnt <= cnt + 4'd1;
            end else if (fall && cnt == 4'd8) begin
              wrdata     <= sr;
              wrstb      <= 1'b1;
              wrfirst    <= first_pend;
              first_pend <= 1'b0;
              sdao       <= 1'b0;
              state      <= S_WACK;
            end
          end
          S_WACK: begin
            if (fall) begin
              sdao  <= 1'b1;
              cnt   <= '0;
              state <= S_WRBYTE;
            end
          end
          S_RDBYTE: begin
            // bit 7 is already on the bus; each fall shifts out the next one
            if (fall) begin
              if (cnt == 4'd7) begin
                sdao  <= 1'b1;
                state <= S_RACK;
              end else begin
                sdao <= sr[6];
                sr   <= {sr[6:0], 1'b0};
                cnt  <= cnt + 4'd1;
              end
            end
          end
          S_RACK: begin
            if (rise) begin
              if (!sda) begin
                rdreq <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else if (fall) begin
              sr    <= rddata;
              sdao  <= rddata[7];
              cnt   <= '0;
              state <= S_RDBYTE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged initiator at 8-CLOCK SCL phases, SYNC = 4.
module tb_i2c_target;

  localparam int HALF = 8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       scl   = 1'b1;
  logic       sda_init = 1'b1;
  logic       sda_bus;
  logic       sdao, wrstb, wrfirst, rdreq, busy;
  logic [7:0] wrdata;
  logic [7:0] rddata = 8'h00;

  int total = 0;
  int bad   = 0;
  int wr_n  = 0;
  int rd_n  = 0;
  int low_n = 0;
  logic [8:0] wr_log [64];

  assign sda_bus = sda_init & sdao;

  i2c_target #(.ADDR(7'h50), .SYNC(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .sclin(scl), .sdai(sda_bus), .sdao(sdao),
    .wrstb(wrstb), .wrdata(wrdata), .wrfirst(wrfirst), .rdreq(rdreq),
    .rddata(rddata), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (wrstb) begin
      wr_log[wr_n[5:0]] <= {wrfirst, wrdata};
      wr_n <= wr_n + 1;
    end
    if (rdreq) rd_n <= rd_n + 1;
    if (!sdao) low_n <= low_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    cyc(HALF/2); sda_init = b;
    cyc(HALF/2); scl = 1'b1;
    cyc(HALF/2); s = sda_bus;
    cyc(HALF/2); scl = 1'b0;
  endtask

  task automatic i2c_start;
    sda_init = 1'b1;
    cyc(HALF); scl = 1'b1;
    cyc(HALF); sda_init = 1'b0;
    cyc(HALF); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    cyc(HALF/2); sda_init = 1'b0;
    cyc(HALF/2); scl = 1'b1;
    cyc(HALF);   sda_init = 1'b1;
    cyc(HALF);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, input logic [7:0] nxt, output logic [7:0] got);
    logic s;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      got = {got[6:0], s};
    end
    rddata = nxt;
    clk_bit(~ack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] got;
    int w0, r0, l0;

    cyc(3);
    RESET = 1'b0;
    cyc(2);
    check("rst_sdao", sdao, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wrstb", wrstb, 1'b0);
    check("rst_rdreq", rdreq, 1'b0);
    check("rst_wrdata", wrdata, 8'h00);
    check("rst_wrfirst", wrfirst, 1'b0);

    // two-byte write
    w0 = wr_n;
    i2c_start;
    write_byte(8'hA0, ack); check("w_addr_ack", ack, 1'b1);
    write_byte(8'h12, ack); check("w_d0_ack", ack, 1'b1);
    write_byte(8'h34, ack); check("w_d1_ack", ack, 1'b1);
    check("w_busy", busy, 1'b1);
    i2c_stop;
    check("w_busy_stop", busy, 1'b0);
    check("w_count", wr_n - w0, 2);
    check("w_log0", wr_log[w0], {1'b1, 8'h12});
    check("w_log1", wr_log[w0 + 1], {1'b0, 8'h34});

    // wrong address
    w0 = wr_n; r0 = rd_n; l0 = low_n;
    i2c_start;
    write_byte(8'hA2, ack); check("na_ack", ack, 1'b0);
    check("na_low", low_n - l0, 0);
    check("na_wr", wr_n - w0, 0);
    check("na_rd", rd_n - r0, 0);
    check("na_busy", busy, 1'b0);
    i2c_stop;

    // two-byte read, ACK then NACK
    r0 = rd_n;
    rddata = 8'h5A;
    i2c_start;
    write_byte(8'hA1, ack); check("r_addr_ack", ack, 1'b1);
    read_byte(1'b1, 8'hC3, got); check("r_b0", got, 8'h5A);
    read_byte(1'b0, 8'h00, got); check("r_b1", got, 8'hC3);
    cyc(2);
    check("r_rdreq", rd_n - r0, 2);
    check("r_busy_nack", busy, 1'b0);
    i2c_stop;

    // write, repeated START, read
    w0 = wr_n; r0 = rd_n;
    i2c_start;
    write_byte(8'hA0, ack); check("rs_waddr_ack", ack, 1'b1);
    write_byte(8'h07, ack); check("rs_wd_ack", ack, 1'b1);
    rddata = 8'h9E;
    i2c_start;
    check("rs_busy_rstart", busy, 1'b0);
    write_byte(8'hA1, ack); check("rs_raddr_ack", ack, 1'b1);
    read_byte(1'b0, 8'h00, got); check("rs_rd", got, 8'h9E);
    i2c_stop;
    check("rs_wr", wr_n - w0, 1);
    check("rs_wlog", wr_log[w0], {1'b1, 8'h07});
    check("rs_rd_n", rd_n - r0, 1);

    // RESET while the target drives bit 3 of a read byte
    rddata = 8'h00;
    i2c_start;
    write_byte(8'hA1, ack); check("mr_addr_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    cyc(HALF - 1);
    check("mr_drive_pre", sdao, 1'b0);
    RESET = 1'b1;
    #1;
    check("mr_release", sdao, 1'b1);
    cyc(1);
    RESET = 1'b0;
    check("mr_wrdata", wrdata, 8'h00);
    l0 = low_n;
    scl = 1'b1; cyc(HALF); scl = 1'b0;
    for (int i = 0; i < 12; i++) clk_bit(1'b1, s);
    check("mr_quiet", low_n - l0, 0);
    check("mr_busy", busy, 1'b0);
    i2c_stop;

    // recovery after reset
    w0 = wr_n;
    i2c_start;
    write_byte(8'hA0, ack); check("rc_addr_ack", ack, 1'b1);
    write_byte(8'h55, ack); check("rc_d_ack", ack, 1'b1);
    i2c_stop;
    check("rc_wlog", wr_log[w0], {1'b1, 8'h55});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
